// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU/datapath/main-memory handshake bundle for cache_ctrl_fsm
//   master: drives mem_read, mem_write, hit, ready; observes controller strobes
//   slave : the controller; drives stall, main_read, main_write, refill, update,
//           rd_valid, word_idx, err
interface cache_ctrl_if #(parameter int IDX_W = 2) ();
  logic mem_read, mem_write, hit, ready;
  logic stall, main_read, main_write, refill, update, rd_valid, err;
  logic [IDX_W-1:0] word_idx;
  modport master (
    output mem_read, mem_write, hit, ready,
    input  stall, main_read, main_write, refill, update, rd_valid, word_idx, err
  );
  modport slave (
    input  mem_read, mem_write, hit, ready,
    output stall, main_read, main_write, refill, update, rd_valid, word_idx, err
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: direct-mapped cache controller with line refill, write-miss policy and timeout
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : cache_ctrl_if.slave (CPU requests, hit/ready in; stall and datapath/memory strobes out)
module cache_ctrl_fsm #(
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = $clog2(WORDS_PER_LINE),
  parameter int WRITE_ALLOCATE = 0,
  parameter int TIMEOUT        = 64,
  parameter int TO_W           = 8
) (
  input logic         clk,
  input logic         reset,
  cache_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_LOOKUP, RD_FILL, WR_LOOKUP, WR_FILL, WR_MEM} state_t;
  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [TO_W-1:0]  tcnt;
  logic             err_q;
  logic             fill, last, to_hit;
  assign fill   = (state == RD_FILL) || (state == WR_FILL);
  assign last   = idx == IDX_W'(WORDS_PER_LINE - 1);
  // tcnt counts the waiting cycles already spent, so the TIMEOUT-th wait ends the transfer
  assign to_hit = (TIMEOUT != 0) && (tcnt == TO_W'(TIMEOUT - 1));
  assign bus.stall      = ((state == RD_LOOKUP) && !bus.hit) || fill ||
                          (state == WR_LOOKUP) || (state == WR_MEM);
  assign bus.rd_valid   = (state == RD_LOOKUP) && bus.hit;
  assign bus.main_read  = fill;
  assign bus.refill     = fill && bus.ready;
  assign bus.update     = (state == WR_LOOKUP) && bus.hit;
  assign bus.main_write = state == WR_MEM;
  assign bus.word_idx   = idx;
  assign bus.err        = err_q;
  // tcnt defaults to zero, which clears it on every state change and every ready
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      tcnt  <= '0;
      case (state)
        IDLE:
          if (bus.mem_read && bus.mem_write) err_q <= 1'b1;
          else if (bus.mem_read) state <= RD_LOOKUP;
          else if (bus.mem_write) state <= WR_LOOKUP;
        RD_LOOKUP:
          if (bus.hit) state <= IDLE;
          else begin
            idx   <= '0;
            state <= RD_FILL;
          end
        WR_LOOKUP:
          if (bus.hit || WRITE_ALLOCATE == 0) state <= WR_MEM;
          else begin
            idx   <= '0;
            state <= WR_FILL;
          end
        RD_FILL, WR_FILL:
          if (bus.ready) begin
            if (last) begin
              idx   <= '0;
              state <= (state == RD_FILL) ? RD_LOOKUP : WR_LOOKUP;
            end else idx <= idx + 1'b1;
          end else if (to_hit) begin
            idx   <= '0;
            err_q <= 1'b1;
            state <= IDLE;
          end else tcnt <= tcnt + 1'b1;
        WR_MEM:
          if (bus.ready) state <= IDLE;
          else if (to_hit) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else tcnt <= tcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
